// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial add/subtract sequencer. Latches two W-bit
//                operands on a start request and walks them LSB-first
//                through a single 1-bit sum cell. The carry is kept in a
//                flop between cycles. Result, carry-out and signed overflow
//                are presented with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_sub,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_s,
  output logic         o_co,
  output logic         o_ov
);

  // Counter just wide enough to index bits 0..W-1.
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;      // operand A shift register, bit 0 is the active bit
  logic [W-1:0]  r_b;      // operand B (already inverted for subtract)
  logic [W-1:0]  r_sr;     // result shift register, filled from the MSB side
  logic          r_carry;  // carry between bit slices
  logic [CW-1:0] r_cnt;    // index of the bit being processed

  logic          w_sum;
  logic          w_cout;
  logic          w_last;
  logic [W-1:0]  w_result;

  // Single-bit full-adder slice shared by every bit position.
  assign w_sum    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last   = (r_cnt == c_LAST_BIT);
  // Final result as it will look once the current sum bit is shifted in.
  assign w_result = {w_sum, r_sr[W-1:1]};

  // Sequencer: operand capture, per-bit shifting and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sr    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_s     <= '0;
      o_co    <= 1'b0;
      o_ov    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sr    <= w_result;
          r_carry <= w_cout;
          if (w_last) begin
            // Overflow: carry into the MSB differs from carry out of it.
            o_s     <= w_result;
            o_co    <= w_cout;
            o_ov    <= r_carry ^ w_cout;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // start is deliberately ignored here; the requester retries in IDLE.
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Directed self-checking bench for serial_add_ctrl (W=8)
//                plus W=2 / W=32 instances checked against a reference sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  // W=8 instance
  logic       i_start, i_sub;
  logic [7:0] i_a, i_b;
  logic       o_busy, o_done, o_co, o_ov;
  logic [7:0] o_s;

  // W=2 and W=32 instances share start/sub
  logic        i_start_w, i_sub_w;
  logic [1:0]  i_a2, i_b2;
  logic [31:0] i_a32, i_b32;
  logic        o_busy2, o_done2, o_co2, o_ov2;
  logic [1:0]  o_s2;
  logic        o_busy32, o_done32, o_co32, o_ov32;
  logic [31:0] o_s32;

  int n_assert = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_sub(i_sub),
    .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done),
    .o_s(o_s), .o_co(o_co), .o_ov(o_ov)
  );

  serial_add_ctrl #(.W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start_w), .i_sub(i_sub_w),
    .i_a(i_a2), .i_b(i_b2), .o_busy(o_busy2), .o_done(o_done2),
    .o_s(o_s2), .o_co(o_co2), .o_ov(o_ov2)
  );

  serial_add_ctrl #(.W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start_w), .i_sub(i_sub_w),
    .i_a(i_a32), .i_b(i_b32), .o_busy(o_busy32), .o_done(o_done32),
    .o_s(o_s32), .o_co(o_co32), .o_ov(o_ov32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One W=8 operation with full timing checks.
  task automatic run8(input string tag, input logic sub, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es, input logic eco, input logic eov);
    logic [7:0] hs;
    logic       hco, hov;
    int         cnt;
    @(negedge clk);
    hs = o_s; hco = o_co; hov = o_ov;
    i_start = 1'b1; i_sub = sub; i_a = a; i_b = b;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_sub = ~sub; i_a = ~a; i_b = ~b;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_busy) break;
      cnt++;
      chk({tag, "_nodone_in_run"}, o_done, 1'b0);
      chk({tag, "_s_hold"}, o_s, hs);
      chk({tag, "_flags_hold"}, {o_co, o_ov}, {hco, hov});
    end
    chk({tag, "_busy_cycles"}, cnt, 8);
    chk({tag, "_done"}, o_done, 1'b1);
    chk({tag, "_s"}, o_s, es);
    chk({tag, "_co"}, o_co, eco);
    chk({tag, "_ov"}, o_ov, eov);
    @(negedge clk);
    chk({tag, "_idle"}, {o_busy, o_done}, 2'b00);
  endtask

  // Simultaneous W=2 and W=32 operation against an arithmetic reference.
  task automatic run_sweep(input logic sub, input logic [31:0] a32, input logic [31:0] b32,
                           input logic [1:0] a2, input logic [1:0] b2);
    logic [32:0] e32;
    logic [2:0]  e2;
    logic [31:0] bb32;
    logic [1:0]  bb2;
    logic        eov32, eov2;
    logic [31:0] hs32;
    logic [1:0]  hs2;
    logic [1:0]  hf32, hf2;
    int          cnt2, cnt32;
    bit          seen2, seen32;
    bb32  = sub ? ~b32 : b32;
    bb2   = sub ? ~b2 : b2;
    e32   = {1'b0, a32} + {1'b0, bb32} + {32'd0, sub};
    e2    = {1'b0, a2} + {1'b0, bb2} + {2'd0, sub};
    eov32 = (a32[31] == bb32[31]) && (e32[31] != a32[31]);
    eov2  = (a2[1] == bb2[1]) && (e2[1] != a2[1]);
    @(negedge clk);
    hs32 = o_s32; hf32 = {o_co32, o_ov32};
    hs2  = o_s2;  hf2  = {o_co2, o_ov2};
    i_start_w = 1'b1; i_sub_w = sub; i_a32 = a32; i_b32 = b32; i_a2 = a2; i_b2 = b2;
    @(posedge clk);
    #1;
    i_start_w = 1'b0; i_sub_w = ~sub; i_a32 = ~a32; i_b32 = ~b32; i_a2 = ~a2; i_b2 = ~b2;
    cnt2 = 0; cnt32 = 0; seen2 = 0; seen32 = 0;
    for (int i = 0; i < 60; i++) begin
      if (seen2 && seen32) break;
      @(negedge clk);
      if (!seen2) begin
        if (o_done2) begin
          seen2 = 1;
          chk("w2_latency", cnt2, 2);
          chk("w2_s", o_s2, e2[1:0]);
          chk("w2_co", o_co2, e2[2]);
          chk("w2_ov", o_ov2, eov2);
        end else begin
          cnt2++;
          chk("w2_busy", o_busy2, 1'b1);
          chk("w2_hold", {o_s2, o_co2, o_ov2}, {hs2, hf2});
        end
      end
      if (!seen32) begin
        if (o_done32) begin
          seen32 = 1;
          chk("w32_latency", cnt32, 32);
          chk("w32_s", o_s32, e32[31:0]);
          chk("w32_co", o_co32, e32[32]);
          chk("w32_ov", o_ov32, eov32);
        end else begin
          cnt32++;
          chk("w32_busy", o_busy32, 1'b1);
          chk("w32_hold", {o_s32, o_co32, o_ov32}, {hs32, hf32});
        end
      end
    end
    chk("w2_done_seen", seen2, 1'b1);
    chk("w32_done_seen", seen32, 1'b1);
    @(negedge clk);
    chk("w32_idle", {o_busy32, o_done32}, 2'b00);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b1;
    i_start = 0; i_sub = 0; i_a = 0; i_b = 0;
    i_start_w = 0; i_sub_w = 0; i_a2 = 0; i_b2 = 0; i_a32 = 0; i_b32 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_w8", {o_busy, o_done, o_s, o_co, o_ov}, 12'd0);
    chk("reset_w2", {o_busy2, o_done2, o_s2, o_co2, o_ov2}, 6'd0);
    chk("reset_w32", {o_busy32, o_done32, o_s32, o_co32, o_ov32}, 36'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed W=8 vectors
    run8("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run8("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    run8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // start pulses during RUN and DONE must be ignored
    @(negedge clk);
    i_start = 1'b1; i_sub = 1'b0; i_a = 8'h01; i_b = 8'h01;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_done) ndone++;
      case (i)
        1:  i_start = 1'b0;
        3:  begin i_start = 1'b1; i_a = 8'hAA; i_b = 8'h55; end
        4:  i_start = 1'b0;
        9:  begin
              chk("ign_done_at_9", o_done, 1'b1);
              i_start = 1'b1;
            end
        10: i_start = 1'b0;
        default: ;
      endcase
    end
    chk("ign_one_done", ndone, 1);
    chk("ign_s", o_s, 8'h02);
    run8("fresh_aa_55", 1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0);

    // Reset in the middle of a run
    @(negedge clk);
    i_start = 1'b1; i_sub = 1'b0; i_a = 8'h7F; i_b = 8'h01;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before_rst", o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {o_busy, o_done, o_s, o_co, o_ov}, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_done || o_busy) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    run8("after_rst_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    // W=2 / W=32 sweep: corners then random
    run_sweep(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 2'b01);
    run_sweep(1'b1, 32'h8000_0000, 32'h0000_0001, 2'b10, 2'b01);
    for (int k = 0; k < 6; k++) begin
      run_sweep(1'($urandom_range(0, 1)), $urandom, $urandom,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer built around the team's 1-bit sum cell. It latches two W-bit operands on a start request and walks them LSB-first through a single bit-slice, keeping the carry in a flop between cycles. It returns the W-bit result, carry-out and signed overflow with a one-cycle done pulse. It is the assembly-line arithmetic stage wherever area matters more than latency.

## Interface
- W, default 8: operand/result width; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse when s/co/ov are updated.
- s  out  W  result, held until the next done.
- co  out  1  carry-out of the MSB (for sub: 1 = no borrow).
- ov  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE: if start=1, then:
  - latch ra=a and rb = sub ? ~b : b;
  - set carry = sub, bit counter = 0;
  - go to RUN.
- If start=0 in IDLE, stay in IDLE.
- RUN, per cycle, on bit k = counter (LSB first):
  - sum bit = ra[0]^rb[0]^carry; new carry = majority(ra[0], rb[0], carry);
  - shift ra and rb right by 1; shift the sum bit into the result shift register at the MSB;
  - increment the counter.
- On the cycle processing bit W-1:
  - capture ov = carry-into-MSB XOR carry-out-of-MSB;
  - go to DONE.
- DONE (one cycle):
  - s, co and ov were loaded on the edge entering DONE; done=1;
  - unconditionally return to IDLE.
- start is ignored in RUN and DONE. Requesters must hold or reissue start once busy=0 and done=0.
- a, b and sub may change freely after the sampling edge; the latched copies are used.
- s, co and ov change only on the edge entering DONE. They are stable at all other times, including throughout RUN.
- Width rules:
  - the counter is ceil(log2(W)) bits and stops at W-1 (no wrap);
  - the result is exactly W bits;
  - the carry beyond co is discarded.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, s=0, co=0, ov=0.
- Reset also clears internal registers: carry=0, counter=0, shift registers=0.
- Reset mid-RUN aborts the operation; no done is produced.
- Deassertion of rst_n is synchronised externally. The first edge after release may sample start.
- Edge E0 samples start=1 in IDLE; busy=1 after E0.
- Edges E1..EW process bits 0..W-1.
- After EW: busy=0, done=1, results valid.
- After E(W+1): done=0, back in IDLE; start may be accepted at E(W+1)+1 at the earliest.
- Throughput: one operation per W+2 cycles. Latency from start edge to done: W cycles.
- busy and done are never high together. busy=0 and done=0 means IDLE.

## Test plan
- W=8, sub=0, a=0x5A, b=0x3C:
  - busy high for exactly 8 cycles, then done one cycle;
  - s=0x96, co=0, ov=1.
- W=8, sub=0, a=0xFF, b=0x01 -> s=0x00, co=1, ov=0.
- W=8, sub=1:
  - a=0x10, b=0x20 -> s=0xF0, co=0, ov=0;
  - a=0x80, b=0x01 -> s=0x7F, co=1, ov=1.
- Start ignored while busy: start a=0x01, b=0x01, then pulse start with a=0xAA, b=0x55 during RUN and during DONE.
  - Exactly one done; s=0x02.
  - A fresh start in IDLE afterwards gives s=0xFF.
- Reset mid-run: assert rst_n=0 at bit 4 of a=0x7F+0x01.
  - All outputs read 0 immediately; no done.
  - After release, a new request 0x7F+0x01 gives s=0x80, ov=1.
- Parameter sweep W=2 and W=32, random operands vs reference model.
  - done exactly W cycles after the start edge.
  - s, co and ov stable throughout RUN.
